load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, cycles the memory needs to settle per access (legal range 1..15).
REQ-002 Parameter BASE_ADDR, default 32'h10000000, first byte address of data memory.
REQ-003 Parameter DEPTH_WORDS, default 32, number of 32-bit words in data memory.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_in  input  1  CPU access request, sampled when ready_out=1.
REQ-007 we_in  input  1  1=store, 0=load.
REQ-008 addr_in  input  32  byte address.
REQ-009 wdata_in  input  32  store data.
REQ-010 size_in  input  2  00=byte, 01=half, 10=word (11 treated as word).
REQ-011 sign_in  input  1  1=sign-extend sub-word load.
REQ-012 ready_out  output  1  unit idle, can accept a request.
REQ-013 done_out  output  1  one-cycle completion pulse.
REQ-014 err_out  output  1  valid with done_out; access rejected.
REQ-015 rdata_out  output  32  load result, held until next load completes.
REQ-016 mem_read_out / mem_write_out  output  1 each  memory read/write controls.
REQ-017 mem_addr_out / mem_wdata_out  output  32 each  memory address/write data.
REQ-018 mem_data_in  input  32  memory read data.

Function
REQ-019 FSM states: IDLE, READ, RMW_READ, WRITE, DONE; ready_out=1 only in IDLE.
REQ-020 Request accepted at edge E0 when req_in=1 in IDLE; addr/data/size/sign/we latched; later input changes ignored until next IDLE.
REQ-021 Reject if addr<BASE_ADDR, addr>BASE_ADDR+4*DEPTH_WORDS-4, word with addr[1:0]!=0, or half with addr[0]!=0: go DONE directly, done_out=err_out=1 in cycle after E0, no memory strobe, rdata_out unchanged.
REQ-022 Load: mem_read_out=1 for cycles C1..C(WAIT_CYCLES) after E0, mem_addr_out=latched addr with [1:0] cleared; mem_data_in captured at end of last cycle; done_out=1 in next cycle.
REQ-023 Word store: mem_addr_out/mem_wdata_out stable C1..C(WAIT_CYCLES); mem_write_out=1 only in last of these cycles; done_out=1 in next cycle.
REQ-024 mem_read_out and mem_write_out never both 1; both 0 in IDLE and DONE.
REQ-025 Wait counter width 4 bits, loads WAIT_CYCLES-1, counts to 0, no wrap.
REQ-026 DONE lasts exactly one cycle, then IDLE; req_in during DONE ignored.
REQ-027 err_out=0 whenever done_out=0.

Reset
REQ-028 rst_n=0 forces IDLE immediately: ready_out=1, done_out=0, err_out=0, mem strobes 0, rdata_out/mem_addr_out/mem_wdata_out=0.
REQ-029 Reset mid-access abandons it with no done_out; a write strobe is deasserted asynchronously.

Configuration
REQ-030 Macro LSU_SUBWORD_EN: when defined, byte/half accesses are honoured; loads extract lane by addr[1:0] and zero/sign-extend per sign_in; stores run RMW_READ (WAIT_CYCLES cycles) then WRITE with merged word, done_out in cycle 2*WAIT_CYCLES+1.
REQ-031 Without LSU_SUBWORD_EN, size_in and sign_in are ignored and every access is a word access.

Structure
REQ-032 Package lsu_pkg holds the state enum, size codes, and default BASE_ADDR/DEPTH_WORDS constants.
REQ-033 Sub-module lsu_lane_merge (combinational) performs load lane extraction/extension and store byte merging; instantiated only under LSU_SUBWORD_EN.

Verification
REQ-034 WAIT_CYCLES=2, memory word 0 = 32'hDEADBEEF; load addr 32'h10000000 -> mem_read_out high 2 cycles, done_out 3rd cycle after accept, rdata_out=32'hDEADBEEF.
REQ-035 Store 32'h12345678 to 32'h1000007C -> single mem_write_out cycle, readback word 31 = 32'h12345678.
REQ-036 Load 32'h10000080, 32'h0FFFFFFC, 32'h10000002 -> done_out=err_out=1 one cycle after accept, no strobe.
REQ-037 rst_n low during READ second cycle -> strobes drop immediately, no done_out, ready_out=1.
REQ-038 LSU_SUBWORD_EN: word 0=32'hDEADBEEF; signed byte load addr 32'h10000001 -> 32'hFFFFFFBE; byte store 8'h55 to 32'h10000002 -> word 0=32'hDE55BEEF, done_out in cycle 5.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access size
// codes, default memory window and the alignment helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4
    } lsu_state_e;

    // Code 2'b11 behaves exactly like a word access.
    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_WORD_X = 2'b11
    } lsu_size_e;

    localparam logic [31:0] LSU_BASE_ADDR_DFLT   = 32'h1000_0000;
    localparam int unsigned LSU_DEPTH_WORDS_DFLT = 32;

    function automatic logic lsu_misaligned(input lsu_size_e sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lo[0];
            default:   bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and data-memory bus of the load/store unit.
// The slave modport is the unit itself; master is the CPU plus memory side.
interface lsu_if;

    logic        req_in;
    logic        we_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [1:0]  size_in;
    logic        sign_in;
    logic        ready_out;
    logic        done_out;
    logic        err_out;
    logic [31:0] rdata_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_data_in;

    modport slave (
        input  req_in, we_in, addr_in, wdata_in, size_in, sign_in, mem_data_in,
        output ready_out, done_out, err_out, rdata_out,
               mem_read_out, mem_write_out, mem_addr_out, mem_wdata_out
    );

    modport master (
        output req_in, we_in, addr_in, wdata_in, size_in, sign_in, mem_data_in,
        input  ready_out, done_out, err_out, rdata_out,
               mem_read_out, mem_write_out, mem_addr_out, mem_wdata_out
    );

endinterface

// File: rtl/lsu_lane_merge.sv
// Combinational byte-lane logic for sub-word accesses (used with LSU_SUBWORD_EN):
// extracts/extends a load lane and merges store data into the word read back.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  lane_i,
    input  lsu_size_e   size_i,
    input  logic        sign_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_lane;
    logic [31:0] half_lane;
    logic [31:0] mask;
    logic [31:0] placed;

    always_comb begin
        byte_sh   = {lane_i, 3'b000};
        half_sh   = {lane_i[1], 4'b0000};
        byte_lane = rd_word_i >> byte_sh;
        half_lane = rd_word_i >> half_sh;
        ld_data_o = rd_word_i;
        mask      = 32'hFFFF_FFFF;
        placed    = st_data_i;
        case (size_i)
            SIZE_BYTE: begin
                ld_data_o = {{24{sign_i & byte_lane[7]}}, byte_lane[7:0]};
                mask      = 32'h0000_00FF << byte_sh;
                placed    = st_data_i << byte_sh;
            end
            SIZE_HALF: begin
                ld_data_o = {{16{sign_i & half_lane[15]}}, half_lane[15:0]};
                mask      = 32'h0000_FFFF << half_sh;
                placed    = st_data_i << half_sh;
            end
            default: begin
                ld_data_o = rd_word_i;
                mask      = 32'hFFFF_FFFF;
                placed    = st_data_i;
            end
        endcase
        st_word_o = (rd_word_i & ~mask) | (placed & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one CPU access at a time against a wait-state data memory.
// Define LSU_SUBWORD_EN to honour byte/half accesses (loads extend, stores do RMW).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = LSU_BASE_ADDR_DFLT,
    parameter int unsigned DEPTH_WORDS = LSU_DEPTH_WORDS_DFLT
) (
    input logic   clk,
    input logic   rst_n,
    lsu_if.slave  bus
);

    localparam logic [31:0] LAST_ADDR   = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd4;
    localparam logic [3:0]  CNT_INIT    = 4'(WAIT_CYCLES - 1);
    localparam logic        WRITE_FIRST = (WAIT_CYCLES == 1);

    lsu_state_e  state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        done_q;
    logic        err_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] rdata_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;

    lsu_size_e   req_size;
    logic        addr_bad;
    logic [31:0] load_word;

`ifdef LSU_SUBWORD_EN
    lsu_size_e   size_q;
    logic        sign_q;
    logic [1:0]  lane_q;
    logic [31:0] store_word;

    assign req_size = lsu_size_e'(bus.size_in);

    // The raw store data sits in mwdata_q during RMW_READ and is replaced by the merged word.
    lsu_lane_merge u_lane_merge (
        .rd_word_i (bus.mem_data_in),
        .st_data_i (mwdata_q),
        .lane_i    (lane_q),
        .size_i    (size_q),
        .sign_i    (sign_q),
        .ld_data_o (load_word),
        .st_word_o (store_word)
    );
`else
    assign req_size  = SIZE_WORD;
    assign load_word = bus.mem_data_in;
`endif

    assign addr_bad = (bus.addr_in < BASE_ADDR) || (bus.addr_in > LAST_ADDR) ||
                      lsu_misaligned(req_size, bus.addr_in[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata_q  <= 32'd0;
            maddr_q  <= 32'd0;
            mwdata_q <= 32'd0;
`ifdef LSU_SUBWORD_EN
            size_q   <= SIZE_WORD;
            sign_q   <= 1'b0;
            lane_q   <= 2'b00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.req_in) begin
                        ready_q <= 1'b0;
                        if (addr_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            cnt_q    <= CNT_INIT;
                            maddr_q  <= {bus.addr_in[31:2], 2'b00};
                            mwdata_q <= bus.wdata_in;
`ifdef LSU_SUBWORD_EN
                            size_q   <= req_size;
                            sign_q   <= bus.sign_in;
                            lane_q   <= bus.addr_in[1:0];
`endif
                            if (!bus.we_in) begin
                                state_q <= READ;
                                rd_q    <= 1'b1;
`ifdef LSU_SUBWORD_EN
                            end else if (req_size == SIZE_BYTE || req_size == SIZE_HALF) begin
                                state_q <= RMW_READ;
                                rd_q    <= 1'b1;
`endif
                            end else begin
                                state_q <= WRITE;
                                wr_q    <= WRITE_FIRST;
                            end
                        end
                    end
                end
                READ: begin
                    if (cnt_q == 4'd0) begin
                        rd_q    <= 1'b0;
                        rdata_q <= load_word;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`ifdef LSU_SUBWORD_EN
                RMW_READ: begin
                    if (cnt_q == 4'd0) begin
                        rd_q     <= 1'b0;
                        mwdata_q <= store_word;
                        cnt_q    <= CNT_INIT;
                        wr_q     <= WRITE_FIRST;
                        state_q  <= WRITE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`endif
                // Address and data are held for the whole window; the strobe fires in its last cycle.
                WRITE: begin
                    if (cnt_q == 4'd0) begin
                        wr_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        wr_q  <= (cnt_q == 4'd1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_out     = ready_q;
    assign bus.done_out      = done_q;
    assign bus.err_out       = err_q;
    assign bus.rdata_out     = rdata_q;
    assign bus.mem_read_out  = rd_q;
    assign bus.mem_write_out = wr_q;
    assign bus.mem_addr_out  = maddr_q;
    assign bus.mem_wdata_out = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with WAIT_CYCLES=2 and a 32-word memory model.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic tb_init;
    logic [31:0] mem [32];
    logic [31:0] off;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit #(
        .WAIT_CYCLES (2),
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign off = bus.mem_addr_out - BASE;
    assign bus.mem_data_in = (off < 32'd128) ? mem[off[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hDEAD_BEEF;
        end else if (bus.mem_write_out && off < 32'd128) begin
            mem[off[6:2]] <= bus.mem_wdata_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!tb_init) begin
            check("rd_wr_exclusive", {31'd0, bus.mem_read_out & bus.mem_write_out}, 32'd0);
            check("err_only_with_done", {31'd0, bus.err_out & ~bus.done_out}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, lets it be accepted, drops req_in; returns in cycle C1.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg);
        bus.req_in   = 1'b1;
        bus.we_in    = we;
        bus.addr_in  = a;
        bus.wdata_in = wd;
        bus.size_in  = sz;
        bus.sign_in  = sg;
        tick();
        bus.req_in   = 1'b0;
    endtask

    logic [31:0] bad_addr [3];

    initial begin
        bad_addr[0] = 32'h1000_0080;
        bad_addr[1] = 32'h0FFF_FFFC;
        bad_addr[2] = 32'h1000_0002;
        bus.req_in = 1'b0; bus.we_in = 1'b0; bus.addr_in = 32'h0;
        bus.wdata_in = 32'h0; bus.size_in = 2'b10; bus.sign_in = 1'b0;
        tb_init = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.ready_out}, 32'd1);
        check("rst_done", {31'd0, bus.done_out}, 32'd0);
        check("rst_err", {31'd0, bus.err_out}, 32'd0);
        check("rst_strobes", {30'd0, bus.mem_read_out, bus.mem_write_out}, 32'd0);
        check("rst_rdata", bus.rdata_out, 32'h0);
        check("rst_mem_addr", bus.mem_addr_out, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata_out, 32'h0);
        tick(); tick();
        #2 rst_n = 1'b1;
        tb_init = 1'b0;
        tick();
        check("idle_ready", {31'd0, bus.ready_out}, 32'd1);

        // Word load from word 0; the later addr_in change must be ignored.
        issue(1'b0, BASE, 32'h0, 2'b10, 1'b0);
        bus.addr_in = 32'h1000_0040;
        check("ld_c1_read", {31'd0, bus.mem_read_out}, 32'd1);
        check("ld_c1_addr", bus.mem_addr_out, BASE);
        check("ld_c1_ready", {31'd0, bus.ready_out}, 32'd0);
        check("ld_c1_done", {31'd0, bus.done_out}, 32'd0);
        tick();
        check("ld_c2_read", {31'd0, bus.mem_read_out}, 32'd1);
        check("ld_c2_addr", bus.mem_addr_out, BASE);
        check("ld_c2_done", {31'd0, bus.done_out}, 32'd0);
        tick();
        check("ld_c3_done", {31'd0, bus.done_out}, 32'd1);
        check("ld_c3_err", {31'd0, bus.err_out}, 32'd0);
        check("ld_c3_read", {31'd0, bus.mem_read_out}, 32'd0);
        check("ld_c3_rdata", bus.rdata_out, 32'hDEAD_BEEF);
        tick();
        check("ld_idle_ready", {31'd0, bus.ready_out}, 32'd1);
        check("ld_idle_done", {31'd0, bus.done_out}, 32'd0);
        check("ld_rdata_held", bus.rdata_out, 32'hDEAD_BEEF);

        // Word store to the last word.
        issue(1'b1, 32'h1000_007C, 32'h1234_5678, 2'b10, 1'b0);
        bus.wdata_in = 32'hFFFF_FFFF;
        check("st_c1_write", {31'd0, bus.mem_write_out}, 32'd0);
        check("st_c1_read", {31'd0, bus.mem_read_out}, 32'd0);
        check("st_c1_addr", bus.mem_addr_out, 32'h1000_007C);
        check("st_c1_wdata", bus.mem_wdata_out, 32'h1234_5678);
        tick();
        check("st_c2_write", {31'd0, bus.mem_write_out}, 32'd1);
        check("st_c2_addr", bus.mem_addr_out, 32'h1000_007C);
        check("st_c2_wdata", bus.mem_wdata_out, 32'h1234_5678);
        tick();
        check("st_c3_done", {31'd0, bus.done_out}, 32'd1);
        check("st_c3_write", {31'd0, bus.mem_write_out}, 32'd0);
        check("st_mem31", mem[31], 32'h1234_5678);
        check("st_rdata_kept", bus.rdata_out, 32'hDEAD_BEEF);
        tick();

        issue(1'b0, 32'h1000_007C, 32'h0, 2'b10, 1'b0);
        tick(); tick();
        check("rb_done", {31'd0, bus.done_out}, 32'd1);
        check("rb_rdata", bus.rdata_out, 32'h1234_5678);
        tick();

        // Rejected accesses.
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, bad_addr[i], 32'h0, 2'b10, 1'b0);
            check("bad_done", {31'd0, bus.done_out}, 32'd1);
            check("bad_err", {31'd0, bus.err_out}, 32'd1);
            check("bad_strobes", {30'd0, bus.mem_read_out, bus.mem_write_out}, 32'd0);
            check("bad_rdata_kept", bus.rdata_out, 32'h1234_5678);
            tick();
            check("bad_after_done", {31'd0, bus.done_out}, 32'd0);
            check("bad_after_err", {31'd0, bus.err_out}, 32'd0);
            check("bad_after_ready", {31'd0, bus.ready_out}, 32'd1);
        end

        // Rejected store: no write strobe, memory untouched.
        issue(1'b1, 32'h1000_0080, 32'hCAFE_0000, 2'b10, 1'b0);
        check("bad_st_err", {31'd0, bus.err_out}, 32'd1);
        check("bad_st_write", {31'd0, bus.mem_write_out}, 32'd0);
        tick();

        // req_in held high through DONE is not taken as a new request.
        bus.req_in = 1'b1; bus.we_in = 1'b0; bus.addr_in = 32'h1000_0080;
        tick();
        check("hold_done", {31'd0, bus.done_out}, 32'd1);
        tick();
        check("hold_idle_ready", {31'd0, bus.ready_out}, 32'd1);
        check("hold_idle_done", {31'd0, bus.done_out}, 32'd0);
        bus.req_in = 1'b0;
        tick();

        // Reset in the second READ cycle.
        issue(1'b0, BASE, 32'h0, 2'b10, 1'b0);
        tick();
        check("rr_c2_read", {31'd0, bus.mem_read_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_read_drop", {31'd0, bus.mem_read_out}, 32'd0);
        check("rr_ready", {31'd0, bus.ready_out}, 32'd1);
        check("rr_done", {31'd0, bus.done_out}, 32'd0);
        check("rr_rdata", bus.rdata_out, 32'h0);
        check("rr_addr", bus.mem_addr_out, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rr_no_done", {31'd0, bus.done_out}, 32'd0);
        check("rr_ready_after", {31'd0, bus.ready_out}, 32'd1);

        // Reset while the write strobe is high.
        issue(1'b1, 32'h1000_0004, 32'hAAAA_5555, 2'b10, 1'b0);
        tick();
        check("rw_c2_write", {31'd0, bus.mem_write_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_write_drop", {31'd0, bus.mem_write_out}, 32'd0);
        check("rw_wdata", bus.mem_wdata_out, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rw_mem1", mem[1], 32'h0);
        check("rw_no_done", {31'd0, bus.done_out}, 32'd0);

`ifdef LSU_SUBWORD_EN
        issue(1'b0, 32'h1000_0001, 32'h0, 2'b00, 1'b1);
        tick(); tick();
        check("sb_ld_done", {31'd0, bus.done_out}, 32'd1);
        check("sb_ld_rdata", bus.rdata_out, 32'hFFFF_FFBE);
        tick();
        issue(1'b0, 32'h1000_0002, 32'h0, 2'b01, 1'b0);
        tick(); tick();
        check("uh_ld_rdata", bus.rdata_out, 32'h0000_DEAD);
        tick();
        issue(1'b1, 32'h1000_0002, 32'h0000_0055, 2'b00, 1'b0);
        check("bst_c1_read", {31'd0, bus.mem_read_out}, 32'd1);
        tick();
        check("bst_c2_read", {31'd0, bus.mem_read_out}, 32'd1);
        tick();
        check("bst_c3_strobes", {30'd0, bus.mem_read_out, bus.mem_write_out}, 32'd0);
        tick();
        check("bst_c4_write", {31'd0, bus.mem_write_out}, 32'd1);
        check("bst_c4_wdata", bus.mem_wdata_out, 32'hDE55_BEEF);
        check("bst_c4_done", {31'd0, bus.done_out}, 32'd0);
        tick();
        check("bst_c5_done", {31'd0, bus.done_out}, 32'd1);
        check("bst_mem0", mem[0], 32'hDE55_BEEF);
        tick();
        issue(1'b0, 32'h1000_0001, 32'h0, 2'b01, 1'b0);
        check("mh_err", {31'd0, bus.err_out}, 32'd1);
        tick();
`else
        // size_in is ignored: a byte request at an odd address is a misaligned word.
        issue(1'b0, 32'h1000_0001, 32'h0, 2'b00, 1'b1);
        check("nb_err", {31'd0, bus.err_out}, 32'd1);
        check("nb_done", {31'd0, bus.done_out}, 32'd1);
        tick();
        issue(1'b0, BASE, 32'h0, 2'b00, 1'b1);
        tick(); tick();
        check("nb_word_rdata", bus.rdata_out, 32'hDEAD_BEEF);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
